// File: rtl/nf_pwm_mc_if.sv
// nf_pwm_mc_if: memory-mapped slave bus between nf_router and nf_pwm_mc.
//
// Signals:
//   addr  32  byte address (master -> slave)
//   we     1  one-cycle write strobe (master -> slave)
//   wd    32  write data (master -> slave)
//   rd    32  read data, combinational from addr (slave -> master)
//
// Handshake: there is no valid/ready pair. The slave is always ready, so a
// write is taken on every rising clk edge where we=1, and rd reflects addr
// in the same cycle with no wait states.
interface nf_pwm_mc_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output addr, output we, output wd, input rd);
    modport slave  (input addr, input we, input wd, output rd);
endinterface

// File: rtl/nf_pwm_mc.sv
// nf_pwm_mc: multi-channel PWM with shared up-counter and shadowed
// period/compare registers that take effect only at the period boundary.
//
// Ports:
//   clk      system clock
//   resetn   asynchronous active-low reset
//   bus      nf_pwm_mc_if slave (addr/we/wd/rd)
//   pwm      CH_NUM PWM outputs
//   irq      period-end interrupt (level, PEF & IE)
//
// Register map (word offset = addr[7:2]):
//   0x00 CTRL    bit0 EN, bit1 IE, bits[8+CH_NUM-1:8] POL
//   0x04 PERIOD  shadow
//   0x08 STATUS  bit0 PEF, write-1-to-clear
//   0x0C COUNT   read-only counter value
//   0x10+4*i CMP[i] shadow
module nf_pwm_mc #(
    parameter int CH_NUM = 4,
    parameter int PWM_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    nf_pwm_mc_if.slave        bus,
    output logic [CH_NUM-1:0] pwm,
    output logic              irq
);

    localparam logic [5:0] W_CTRL   = 6'd0;
    localparam logic [5:0] W_PERIOD = 6'd1;
    localparam logic [5:0] W_STATUS = 6'd2;
    localparam logic [5:0] W_COUNT  = 6'd3;
    localparam int         W_CMP0   = 4;

    logic [5:0] word;
    assign word = bus.addr[7:2];

    // Address bits outside [7:2] and unused data bits are ignored by design.
    logic unused_bits;
    assign unused_bits = ^{bus.addr[31:8], bus.addr[1:0], bus.wd};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                          en_q, en_d;
    logic                          ie_q, ie_d;
    logic [CH_NUM-1:0]             pol_q, pol_d;
    logic                          pef_q, pef_d;
    logic [PWM_W-1:0]              period_sh_q, period_sh_d;
    logic [PWM_W-1:0]              period_act_q, period_act_d;
    logic [CH_NUM-1:0][PWM_W-1:0]  cmp_sh_q, cmp_sh_d;
    logic [CH_NUM-1:0][PWM_W-1:0]  cmp_act_q, cmp_act_d;
    logic [PWM_W-1:0]              cnt_q, cnt_d;

    logic wrap;
    assign wrap = en_q && (cnt_q == period_act_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        en_d         = en_q;
        ie_d         = ie_q;
        pol_d        = pol_q;
        pef_d        = pef_q;
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;
        cmp_sh_d     = cmp_sh_q;
        cmp_act_d    = cmp_act_q;
        cnt_d        = cnt_q;

        if (bus.we) begin
            if (word == W_CTRL) begin
                en_d  = bus.wd[0];
                ie_d  = bus.wd[1];
                pol_d = bus.wd[8 +: CH_NUM];
            end
            if (word == W_PERIOD) begin
                period_sh_d = bus.wd[PWM_W-1:0];
            end
            if ((word == W_STATUS) && bus.wd[0]) begin
                pef_d = 1'b0;
            end
            for (int i = 0; i < CH_NUM; i++) begin
                if (word == 6'(W_CMP0 + i)) begin
                    cmp_sh_d[i] = bus.wd[PWM_W-1:0];
                end
            end
        end

        // Actives load from the shadow values held before this edge, so a
        // write landing on a wrap edge waits one full period.
        if (!en_q || wrap) begin
            period_act_d = period_sh_q;
            cmp_act_d    = cmp_sh_q;
        end

        // Counter is held at zero whenever EN is (or is about to be) low.
        if (!en_q || !en_d || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PWM_W'(1);
        end

        // A wrap on the same edge as a W1C keeps the flag set.
        if (wrap) begin
            pef_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q         <= 1'b0;
            ie_q         <= 1'b0;
            pol_q        <= '0;
            pef_q        <= 1'b0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            cmp_sh_q     <= '0;
            cmp_act_q    <= '0;
            cnt_q        <= '0;
        end else begin
            en_q         <= en_d;
            ie_q         <= ie_d;
            pol_q        <= pol_d;
            pef_q        <= pef_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            cmp_sh_q     <= cmp_sh_d;
            cmp_act_q    <= cmp_act_d;
            cnt_q        <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (returns shadow values, zero-extended)
    // ------------------------------------------------------------------
    logic [31:0] rd_w;

    always_comb begin
        rd_w = '0;
        case (word)
            W_CTRL: begin
                rd_w[0]           = en_q;
                rd_w[1]           = ie_q;
                rd_w[8 +: CH_NUM] = pol_q;
            end
            W_PERIOD: rd_w[PWM_W-1:0] = period_sh_q;
            W_STATUS: rd_w[0]         = pef_q;
            W_COUNT:  rd_w[PWM_W-1:0] = cnt_q;
            default: begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (word == 6'(W_CMP0 + i)) begin
                        rd_w[PWM_W-1:0] = cmp_sh_q[i];
                    end
                end
            end
        endcase
    end

    assign bus.rd = rd_w;

    // ------------------------------------------------------------------
    // Outputs: driven from registers only
    // ------------------------------------------------------------------
    always_comb begin
        pwm = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (en_q) begin
                pwm[i] = (cnt_q < cmp_act_q[i]) ^ pol_q[i];
            end else begin
                pwm[i] = pol_q[i];
            end
        end
    end

    assign irq = pef_q & ie_q;

endmodule

// File: tb/tb_nf_pwm_mc.sv
// tb_nf_pwm_mc: self-checking bench for nf_pwm_mc (CH_NUM=4, PWM_W=16).
// A behavioural register/period model predicts rd, pwm and irq every cycle;
// directed scenarios add duty-cycle and interrupt checks on top.
module tb_nf_pwm_mc;

    localparam int          CH     = 4;
    localparam int          W      = 16;
    localparam logic [31:0] MASK   = 32'h0000_FFFF;
    localparam int          BOUND  = 60;

    logic clk;
    logic resetn;
    logic [CH-1:0] pwm;
    logic irq;

    nf_pwm_mc_if bus ();

    nf_pwm_mc #(.CH_NUM(CH), .PWM_W(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave),
        .pwm    (pwm),
        .irq    (irq)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (register-level view of the block)
    // ------------------------------------------------------------------
    bit          m_en, m_ie, m_pef;
    int unsigned m_pol;
    int unsigned m_per_sh, m_per_act, m_cnt;
    int unsigned m_cmp_sh[CH];
    int unsigned m_cmp_act[CH];

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_pef = 0; m_pol = 0;
        m_per_sh = 0; m_per_act = 0; m_cnt = 0;
        for (int i = 0; i < CH; i++) begin
            m_cmp_sh[i]  = 0;
            m_cmp_act[i] = 0;
        end
    endtask

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        int unsigned word;
        bit          at_end;
        word   = (a >> 2) & 32'd63;
        at_end = m_en && (m_cnt == m_per_act);
        // Period boundary (or disabled): shadows become active.
        if (!m_en || at_end) begin
            m_per_act = m_per_sh;
            for (int i = 0; i < CH; i++) m_cmp_act[i] = m_cmp_sh[i];
        end
        m_cnt = (!m_en || at_end) ? 0 : m_cnt + 1;
        if (w) begin
            if (word == 0) begin
                m_en  = d[0];
                m_ie  = d[1];
                m_pol = (d >> 8) & ((1 << CH) - 1);
            end else if (word == 1) begin
                m_per_sh = d & MASK;
            end else if (word == 2) begin
                if (d[0]) m_pef = 0;
            end else if (word >= 4 && word < 4 + CH) begin
                m_cmp_sh[word - 4] = d & MASK;
            end
        end
        if (!m_en) m_cnt = 0;
        if (at_end) m_pef = 1;
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int unsigned word;
        word = (a >> 2) & 32'd63;
        if (word == 0) return (m_pol << 8) | (32'(m_ie) << 1) | 32'(m_en);
        if (word == 1) return m_per_sh;
        if (word == 2) return 32'(m_pef);
        if (word == 3) return m_cnt;
        if (word >= 4 && word < 4 + CH) return m_cmp_sh[word - 4];
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_pwm();
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < CH; i++) begin
            if (m_en) r[i] = (m_cnt < m_cmp_act[i]) ^ m_pol[i];
            else      r[i] = m_pol[i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Driver: one bus cycle, checked against the model
    // ------------------------------------------------------------------
    task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [CH-1:0] p_obs, output logic [31:0] r_obs);
        @(negedge clk);
        bus.we   = w;
        bus.addr = a;
        bus.wd   = d;
        #1;
        exp_q.push_back(exp_rd(a));
        exp_q.push_back(exp_pwm());
        exp_q.push_back(32'(m_pef & m_ie));
        p_obs = pwm;
        r_obs = bus.rd;
        check_eq("rd",  bus.rd,     exp_q.pop_front());
        check_eq("pwm", 32'(pwm),   exp_q.pop_front());
        check_eq("irq", 32'(irq),   exp_q.pop_front());
        @(posedge clk);
        if (resetn) model_step(w, a, d);
        else        model_reset();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [CH-1:0] p;
        logic [31:0]   r;
        cycle(1'b1, a, d, p, r);
    endtask

    task automatic idle(output logic [CH-1:0] p);
        logic [31:0] r;
        cycle(1'b0, 32'h0C, 32'd0, p, r);
    endtask

    // Returns at the cycle where COUNT reads target; the next cycle sees target+1.
    task automatic wait_count(input logic [31:0] target, input string tag);
        logic [CH-1:0] p;
        logic [31:0]   r;
        r = 32'hFFFF_FFFF;
        for (int g = 0; g < BOUND; g++) begin
            cycle(1'b0, 32'h0C, 32'd0, p, r);
            if (r == target) break;
        end
        check_eq(tag, r, target);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [CH-1:0] p;
        logic [31:0]   r;
        int            hi[CH];
        int            h;

        resetn   = 1'b0;
        bus.we   = 1'b0;
        bus.addr = '0;
        bus.wd   = '0;
        model_reset();

        // 1. Reset held with random bus activity.
        for (int k = 0; k < 8; k++) begin
            cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 2, $urandom, p, r);
        end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 32'(k) << 2, 32'd0, p, r);
            check_eq("rst_rd", r, 32'd0);
        end
        check_eq("rst_pwm", 32'(pwm), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // 2. Four channels, period 10.
        wr(32'h04, 32'd9);
        wr(32'h10, 32'd3);
        wr(32'h14, 32'd0);
        wr(32'h18, 32'd10);
        wr(32'h1C, 32'd9);
        wr(32'h00, 32'h1);
        for (int i = 0; i < CH; i++) hi[i] = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 32'h0C, 32'd0, p, r);
            check_eq("sweep", r, 32'(k % 10));
            for (int i = 0; i < CH; i++) hi[i] += int'(p[i]);
        end
        check_eq("duty0", 32'(hi[0]), 32'd6);
        check_eq("duty1", 32'(hi[1]), 32'd0);
        check_eq("duty2", 32'(hi[2]), 32'd20);
        check_eq("duty3", 32'(hi[3]), 32'd18);

        // 3. CMP0 change mid-period waits for the boundary.
        wait_count(32'd3, "wait_c3");
        wr(32'h10, 32'd7);
        h = 0;
        for (int k = 0; k < 5; k++) begin idle(p); h += int'(p[0]); end
        check_eq("cur_period_hi", 32'(h), 32'd0);
        h = 0;
        for (int k = 0; k < 10; k++) begin idle(p); h += int'(p[0]); end
        check_eq("next_period_hi", 32'(h), 32'd7);

        // 4. Inverted polarity.
        wr(32'h00, 32'h100);
        wr(32'h10, 32'd3);
        idle(p);
        check_eq("idle_pol", 32'(p[0]), 32'd1);
        wr(32'h00, 32'h101);
        h = 0;
        for (int k = 0; k < 10; k++) begin
            idle(p);
            check_eq("pol_shape", 32'(p[0]), 32'(k >= 3));
            h += int'(p[0]);
        end
        check_eq("pol_hi", 32'(h), 32'd7);

        // 5. Interrupt and W1C, including W1C on a wrap edge.
        wr(32'h00, 32'h2);
        wr(32'h08, 32'h1);
        wr(32'h04, 32'd4);
        wr(32'h00, 32'h3);
        wait_count(32'd3, "wait_i3");
        idle(p);
        check_eq("irq_before_wrap", 32'(irq), 32'd0);
        wr(32'h08, 32'h1);
        idle(p);
        check_eq("irq_w1c", 32'(irq), 32'd0);
        wr(32'h08, 32'h0);
        wait_count(32'd3, "wait_i3b");
        wr(32'h08, 32'h1);
        idle(p);
        check_eq("irq_set_wins", 32'(irq), 32'd1);

        // 6. Asynchronous reset mid-period.
        wr(32'h04, 32'd9);
        wr(32'h10, 32'd7);
        wait_count(32'd5, "wait_c5");
        #2;
        resetn = 1'b0;
        #1;
        check_eq("arst_pwm", 32'(pwm), 32'd0);
        check_eq("arst_irq", 32'(irq), 32'd0);
        bus.addr = 32'h0C;
        #1;
        check_eq("arst_count", bus.rd, 32'd0);
        bus.addr = 32'h10;
        #1;
        check_eq("arst_cmp0", bus.rd, 32'd0);
        model_reset();
        idle(p);
        @(negedge clk);
        resetn = 1'b1;

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            int sel;
            logic [31:0] a, d;
            logic        w;
            sel = $urandom_range(0, 99);
            w   = 1'b1;
            if (sel < 8) begin
                a = 32'h00;
                d = (32'($urandom_range(0, 15)) << 8) | (32'($urandom_range(0, 1)) << 1)
                    | 32'($urandom_range(0, 9) != 0);
            end else if (sel < 15) begin
                a = 32'h08;
                d = $urandom;
            end else if (sel < 45) begin
                a = 32'h10 + (32'($urandom_range(0, CH - 1)) << 2);
                d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 14));
            end else if (sel < 55) begin
                a = 32'h04;
                d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
            end else if (sel < 65) begin
                case ($urandom_range(0, 3))
                    0: a = 32'h0C;
                    1: a = 32'h20;
                    2: a = 32'h3C;
                    default: a = 32'hFC;
                endcase
                d = $urandom;
            end else begin
                w = 1'b0;
                a = 32'($urandom_range(0, 15)) << 2;
                d = $urandom;
            end
            cycle(w, a, d, p, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
